mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Load/store access unit between the CPU MEM stage and the data-side word RAM.
- RAM interface: combinational read; write on the negedge with a 4-bit byte-write mask.
- Accepts one load or store request at a time over a valid/ready handshake and detects misalignment.
- Drives the RAM for exactly one cycle, then returns aligned, sign- or zero-extended load data over a valid/ready response channel.

Parameters:
- ADDR_W, 32, width of request and RAM addresses.
- ERR_ON_ILLEGAL_SIZE, 1, when 1 a size code of 2'b11 returns an error response; when 0 it is treated as a word access.

Ports:
- clk  input  1  system clock; all state updates on the posedge.
- rst  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  input  ADDR_W  byte address.
- req_wdata  input  32  store data, right-justified.
- resp_valid  output  1  response available.
- resp_ready  input  1  consumer accepts the response.
- resp_rdata  output  32  extended load data; 0 for stores and errors.
- resp_err  output  1  misaligned or illegal access.
- mem_ce  output  1  RAM chip enable, active-high.
- mem_re  output  1  RAM read enable, active-high.
- mem_we  output  1  RAM write enable, active-high.
- mem_read_addr  output  ADDR_W  word-aligned read address.
- mem_read_data  input  32  RAM read word (combinational).
- mem_write_addr  output  ADDR_W  word-aligned write address.
- mem_write_data  output  32  lane-shifted store data.
- mem_write_mask  output  4  byte lanes; bit 3 = bits 31:24.

Behaviour:
- States: IDLE, ACCESS, RESP.
- Reset (rst low, asynchronous): state IDLE, req_ready 0 while rst is low, resp_valid 0, resp_rdata 0, resp_err 0, all mem_* outputs 0, latched request cleared.
- IDLE:
  - req_ready = 1.
  - On posedge with req_valid: latch we, size, unsigned, addr, wdata.
  - Misalignment: half with addr[0]=1, or word with addr[1:0]!=0, or size 11 when ERR_ON_ILLEGAL_SIZE=1. On misalignment go to RESP with err=1, rdata=0, and no RAM cycle. Otherwise go to ACCESS.
- ACCESS (exactly one cycle):
  - req_ready = 0; mem_ce = 1.
  - Both RAM addresses = {addr[ADDR_W-1:2], 2'b00}.
  - Load: mem_re = 1, mem_we = 0; at the posedge capture the selected lane from mem_read_data, extend it, go to RESP.
  - Store: mem_we = 1, mem_re = 0. The RAM commits at the mid-cycle negedge; go to RESP with rdata 0.
- Lane mapping (big-endian): byte offset k uses bits [31-8k:24-8k] and mask bit 3-k. Half offset 0 uses bits [31:16] and mask 1100; offset 2 uses bits [15:0] and mask 0011. Word uses mask 1111.
- Store data: the low byte/half of wdata is replicated into the selected lane. Unselected lanes carry don't-care data with mask bit 0.
- Extension: byte → 8 to 32 bits, half → 16 to 32 bits; sign bit = MSB of the selected lane unless unsigned.
- mem_* outputs are 0 in every state except ACCESS.
- RESP:
  - resp_valid = 1; resp_rdata and resp_err are held stable until the handshake.
  - On posedge with resp_ready: go to IDLE and clear resp_valid.
  - A new request is accepted no earlier than the cycle after the handshake; back-to-back throughput is 1 request per 3 cycles.
- Latency: request accept → resp_valid is 2 cycles for a RAM access, 1 cycle for an error.
- Reset asserted in ACCESS aborts the access. A store whose negedge has not yet occurred must not be written, because mem_we drops asynchronously. In any state, reset discards a pending response.
- req_valid is ignored outside IDLE. resp_ready is ignored outside RESP.

Test Plan:
- Store word 0xDEADBEEF to 0x10, then load word from 0x10 → in ACCESS, write mask 1111 and write address 0x10; the load returns resp_rdata 0xDEADBEEF, resp_err 0, 2 cycles after accept.
- Store byte 0x80 to 0x21; signed load byte from 0x21 → mask 0100, mem_write_data[23:16]=0x80; load returns 0xFFFFFF80. Unsigned load byte returns 0x00000080.
- Store half 0x8001 to 0x32; signed and unsigned load half from 0x32 → mask 0011; load returns 0xFFFF8001 (signed) and 0x00008001 (unsigned). Other bytes of word 0x30 are unchanged.
- Load word from 0x13 and load half from 0x05 → resp_err 1, resp_rdata 0, mem_ce never asserted, 1-cycle latency.
- Hold resp_ready low for 5 cycles after resp_valid → resp_valid and data stay stable, req_ready stays 0, a new request with req_valid high is not accepted until the cycle after resp_ready.
- Assert rst low mid-ACCESS of a store to 0x40 before the negedge → outputs go to reset values immediately, word 0x40 is unmodified, next request is accepted normally after rst rises.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store access unit: takes one MEM-stage request at a time, runs a single
// RAM cycle (or flags a misaligned/illegal access) and returns extended load data.
module mem_access_unit #(
    parameter int ADDR_W              = 32,
    parameter bit ERR_ON_ILLEGAL_SIZE = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_ce,
    output logic              mem_re,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_read_addr,
    input  logic [31:0]       mem_read_data,
    output logic [ADDR_W-1:0] mem_write_addr,
    output logic [31:0]       mem_write_data,
    output logic [3:0]        mem_write_mask,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    // Handshakes: a transfer happens on a posedge where valid and ready are both 1.
    // req_ready is high only in IDLE; resp_valid is high only in RESP.
    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              resp_valid_q, resp_valid_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;
    logic              resp_err_q, resp_err_d;
    logic              mem_ce_q, mem_ce_d;
    logic              mem_re_q, mem_re_d;
    logic              mem_we_q, mem_we_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [3:0]        mem_mask_q, mem_mask_d;

    logic        misaligned;
    logic [31:0] lane_wdata;
    logic [3:0]  lane_mask;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_ext;

    always_comb begin
        misaligned = 1'b0;
        lane_wdata = req_wdata;
        lane_mask  = 4'b1111;
        case (req_size)
            2'b00: begin
                lane_wdata = {4{req_wdata[7:0]}};
                lane_mask  = 4'b1000 >> req_addr[1:0];
            end
            2'b01: begin
                misaligned = req_addr[0];
                lane_wdata = {2{req_wdata[15:0]}};
                lane_mask  = req_addr[1] ? 4'b0011 : 4'b1100;
            end
            2'b10:   misaligned = |req_addr[1:0];
            default: misaligned = ERR_ON_ILLEGAL_SIZE ? 1'b1 : |req_addr[1:0];
        endcase
    end

    // Big-endian lane select: byte offset 0 lives in bits 31:24.
    always_comb begin
        byte_sel = mem_read_data[7:0];
        case (addr_q[1:0])
            2'd0:    byte_sel = mem_read_data[31:24];
            2'd1:    byte_sel = mem_read_data[23:16];
            2'd2:    byte_sel = mem_read_data[15:8];
            default: byte_sel = mem_read_data[7:0];
        endcase
        half_sel = addr_q[1] ? mem_read_data[15:0] : mem_read_data[31:16];
        case (size_q)
            2'b00:   load_ext = {{24{~uns_q & byte_sel[7]}}, byte_sel};
            2'b01:   load_ext = {{16{~uns_q & half_sel[15]}}, half_sel};
            default: load_ext = mem_read_data;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        size_d       = size_q;
        uns_d        = uns_q;
        addr_d       = addr_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        mem_ce_d     = 1'b0;
        mem_re_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_wdata_d  = '0;
        mem_mask_d   = '0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d   = req_we;
                    size_d = req_size;
                    uns_d  = req_unsigned;
                    addr_d = req_addr;
                    if (misaligned) begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_rdata_d = '0;
                        resp_err_d   = 1'b1;
                    end else begin
                        state_d     = S_ACCESS;
                        mem_ce_d    = 1'b1;
                        mem_re_d    = ~req_we;
                        mem_we_d    = req_we;
                        mem_wdata_d = lane_wdata;
                        mem_mask_d  = req_we ? lane_mask : 4'b0000;
                    end
                end
            end
            S_ACCESS: begin
                state_d      = S_RESP;
                resp_valid_d = 1'b1;
                resp_rdata_d = we_q ? 32'h0 : load_ext;
                resp_err_d   = 1'b0;
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d      = S_IDLE;
                    resp_valid_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Async clear drops mem_we mid-cycle, so an aborted store never reaches the negedge write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            we_q         <= 1'b0;
            size_q       <= 2'b00;
            uns_q        <= 1'b0;
            addr_q       <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            mem_ce_q     <= 1'b0;
            mem_re_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_wdata_q  <= '0;
            mem_mask_q   <= '0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            addr_q       <= addr_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            mem_ce_q     <= mem_ce_d;
            mem_re_q     <= mem_re_d;
            mem_we_q     <= mem_we_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_mask_q   <= mem_mask_d;
        end
    end

    assign req_ready      = (state_q == S_IDLE) && rst;
    assign resp_valid     = resp_valid_q;
    assign resp_rdata     = resp_rdata_q;
    assign resp_err       = resp_err_q;
    assign mem_ce         = mem_ce_q;
    assign mem_re         = mem_re_q;
    assign mem_we         = mem_we_q;
    assign mem_read_addr  = mem_ce_q ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign mem_write_addr = mem_ce_q ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign mem_write_data = mem_wdata_q;
    assign mem_write_mask = mem_mask_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: word RAM model, vector table of load/store requests,
// plus hand-written back-pressure and reset-abort sequences.
module tb_mem_access_unit;

  localparam int ADDR_W = 32;

  logic              clk;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              mem_ce;
  logic              mem_re;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_read_addr;
  logic [31:0]       mem_read_data;
  logic [ADDR_W-1:0] mem_write_addr;
  logic [31:0]       mem_write_data;
  logic [3:0]        mem_write_mask;
  logic [1:0]        dbg_state;

  mem_access_unit #(.ADDR_W(ADDR_W), .ERR_ON_ILLEGAL_SIZE(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .mem_ce(mem_ce), .mem_re(mem_re), .mem_we(mem_we),
    .mem_read_addr(mem_read_addr), .mem_read_data(mem_read_data),
    .mem_write_addr(mem_write_addr), .mem_write_data(mem_write_data),
    .mem_write_mask(mem_write_mask), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // word RAM: combinational read, masked write on the negedge
  logic [31:0] ram [0:255];
  assign mem_read_data = ram[mem_read_addr[9:2]];
  always @(negedge clk) begin
    if (mem_ce && mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_write_mask[b]) ram[mem_write_addr[9:2]][8*b +: 8] <= mem_write_data[8*b +: 8];
    end
  end

  // scoreboard
  logic [32:0] exp_q[$];
  int n_cmp;
  int n_fail;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_resp();
    logic [32:0] e;
    if (exp_q.size() == 0) begin
      chk("exp_q_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk("resp_rdata", resp_rdata, e[31:0]);
      chk("resp_err", {31'd0, resp_err}, {31'd0, e[32]});
    end
  endtask

  function automatic logic [31:0] expand(input logic [3:0] m);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = {8{m[b]}};
    return r;
  endfunction

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [3:0]  exp_mask;
    logic [31:0] exp_lane;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp_rdata, input logic exp_err,
                              input logic [3:0] exp_mask, input logic [31:0] exp_lane);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_mask = exp_mask; v.exp_lane = exp_lane;
    return v;
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge after the response handshake.
  task automatic run_txn(input vec_t t);
    exp_q.push_back({t.exp_err, t.exp_rdata});
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = t.we; req_size = t.size; req_unsigned = t.uns;
    req_addr = t.addr; req_wdata = t.wdata;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_addr = $urandom_range(0, 255);
    req_wdata = $urandom;
    if (!t.exp_err) begin
      chk("mem_ce_access", {31'd0, mem_ce}, 32'd1);
      chk("mem_we_access", {31'd0, mem_we}, {31'd0, t.we});
      chk("mem_re_access", {31'd0, mem_re}, {31'd0, ~t.we});
      if (t.we) begin
        chk("write_addr", mem_write_addr, {t.addr[31:2], 2'b00});
        chk("write_mask", {28'd0, mem_write_mask}, {28'd0, t.exp_mask});
        chk("write_lane", mem_write_data & expand(t.exp_mask), t.exp_lane);
      end else begin
        chk("read_addr", mem_read_addr, {t.addr[31:2], 2'b00});
      end
      chk("resp_valid_early", {31'd0, resp_valid}, 32'd0);
      @(negedge clk);
    end else begin
      chk("mem_ce_err", {31'd0, mem_ce}, 32'd0);
    end
    chk("resp_valid_latency", {31'd0, resp_valid}, 32'd1);
    chk("mem_ce_resp", {31'd0, mem_ce}, 32'd0);
    chk("req_ready_busy", {31'd0, req_ready}, 32'd0);
    check_resp();
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    chk("resp_valid_cleared", {31'd0, resp_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra;
    logic [31:0] rd;
    n_cmp = 0; n_fail = 0;
    for (int i = 0; i < 256; i++) ram[i] = 32'h0;
    ram[16] = 32'h5A5A5A5A;
    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; resp_ready = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
    chk("rst_mem_ctl", {29'd0, mem_ce, mem_re, mem_we}, 32'd0);
    chk("rst_mem_mask", {28'd0, mem_write_mask}, 32'd0);
    chk("rst_state", {30'd0, dbg_state}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    //                we    size  uns  addr   wdata         exp_rdata     err  mask  lane
    vecs.push_back(mk(1'b1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h00000000, 0, 4'hF, 32'hDEADBEEF));
    vecs.push_back(mk(1'b0, 2'b10, 0, 32'h10, 32'h0,        32'hDEADBEEF, 0, 4'h0, 32'h0));
    vecs.push_back(mk(1'b1, 2'b00, 0, 32'h21, 32'hCAFE0080, 32'h00000000, 0, 4'h4, 32'h00800000));
    vecs.push_back(mk(1'b0, 2'b00, 0, 32'h21, 32'h0,        32'hFFFFFF80, 0, 4'h0, 32'h0));
    vecs.push_back(mk(1'b0, 2'b00, 1, 32'h21, 32'h0,        32'h00000080, 0, 4'h0, 32'h0));
    vecs.push_back(mk(1'b1, 2'b10, 0, 32'h30, 32'h11223344, 32'h00000000, 0, 4'hF, 32'h11223344));
    vecs.push_back(mk(1'b1, 2'b01, 0, 32'h32, 32'h12348001, 32'h00000000, 0, 4'h3, 32'h00008001));
    vecs.push_back(mk(1'b0, 2'b01, 0, 32'h32, 32'h0,        32'hFFFF8001, 0, 4'h0, 32'h0));
    vecs.push_back(mk(1'b0, 2'b01, 1, 32'h32, 32'h0,        32'h00008001, 0, 4'h0, 32'h0));
    vecs.push_back(mk(1'b0, 2'b10, 0, 32'h30, 32'h0,        32'h11228001, 0, 4'h0, 32'h0));
    vecs.push_back(mk(1'b0, 2'b00, 0, 32'h30, 32'h0,        32'h00000011, 0, 4'h0, 32'h0));
    vecs.push_back(mk(1'b0, 2'b01, 1, 32'h30, 32'h0,        32'h00001122, 0, 4'h0, 32'h0));
    vecs.push_back(mk(1'b1, 2'b01, 0, 32'h34, 32'h0000F00D, 32'h00000000, 0, 4'hC, 32'hF00D0000));
    vecs.push_back(mk(1'b1, 2'b00, 0, 32'h37, 32'h000000AB, 32'h00000000, 0, 4'h1, 32'h000000AB));
    vecs.push_back(mk(1'b1, 2'b00, 0, 32'h36, 32'h0000005C, 32'h00000000, 0, 4'h2, 32'h00005C00));
    vecs.push_back(mk(1'b0, 2'b01, 0, 32'h34, 32'h0,        32'hFFFFF00D, 0, 4'h0, 32'h0));
    vecs.push_back(mk(1'b0, 2'b00, 0, 32'h37, 32'h0,        32'hFFFFFFAB, 0, 4'h0, 32'h0));
    vecs.push_back(mk(1'b0, 2'b00, 1, 32'h36, 32'h0,        32'h0000005C, 0, 4'h0, 32'h0));
    vecs.push_back(mk(1'b0, 2'b10, 0, 32'h13, 32'h0,        32'h00000000, 1, 4'h0, 32'h0));
    vecs.push_back(mk(1'b0, 2'b01, 0, 32'h05, 32'h0,        32'h00000000, 1, 4'h0, 32'h0));
    vecs.push_back(mk(1'b0, 2'b11, 0, 32'h30, 32'h0,        32'h00000000, 1, 4'h0, 32'h0));
    vecs.push_back(mk(1'b1, 2'b01, 0, 32'h37, 32'h0000FFFF, 32'h00000000, 1, 4'h0, 32'h0));
    vecs.push_back(mk(1'b1, 2'b10, 0, 32'h3A, 32'hFFFFFFFF, 32'h00000000, 1, 4'h0, 32'h0));
    vecs.push_back(mk(1'b0, 2'b10, 0, 32'h34, 32'h0,        32'hF00D5CAB, 0, 4'h0, 32'h0));

    foreach (vecs[i]) begin
      run_txn(vecs[i]);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // random word store / load-back pairs in an untouched region
    for (int i = 0; i < 6; i++) begin
      ra = {24'd0, 2'b10, 4'(i), 2'b00};
      rd = $urandom;
      run_txn(mk(1'b1, 2'b10, 0, ra, rd, 32'h0, 0, 4'hF, rd));
      run_txn(mk(1'b0, 2'b10, 0, ra, 32'h0, rd, 0, 4'h0, 32'h0));
    end

    // back-pressure: response held for 5 cycles while a second request waits
    exp_q.push_back({1'b0, 32'hDEADBEEF});
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h10;
    @(posedge clk);
    @(negedge clk);
    req_size = 2'b00; req_unsigned = 1'b1; req_addr = 32'h21;
    @(negedge clk);
    chk("bp_resp_valid", {31'd0, resp_valid}, 32'd1);
    check_resp();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_hold_valid", {31'd0, resp_valid}, 32'd1);
      chk("bp_hold_rdata", resp_rdata, 32'hDEADBEEF);
      chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
      chk("bp_no_access", {31'd0, mem_ce}, 32'd0);
    end
    exp_q.push_back({1'b0, 32'h00000080});
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    chk("bp_after_hs_valid", {31'd0, resp_valid}, 32'd0);
    chk("bp_after_hs_ready", {31'd0, req_ready}, 32'd1);
    chk("bp_not_yet_accepted", {31'd0, mem_ce}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("bp_second_access", {31'd0, mem_ce & mem_re}, 32'd1);
    @(negedge clk);
    chk("bp_second_valid", {31'd0, resp_valid}, 32'd1);
    check_resp();
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;

    // reset during a store's ACCESS cycle, before the RAM negedge
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h40; req_wdata = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    chk("abort_in_access", {31'd0, mem_we}, 32'd1);
    rst = 1'b0;
    req_valid = 1'b0;
    #1;
    chk("abort_mem_we", {31'd0, mem_we}, 32'd0);
    chk("abort_mem_ce", {31'd0, mem_ce}, 32'd0);
    chk("abort_req_ready", {31'd0, req_ready}, 32'd0);
    chk("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("abort_state", {30'd0, dbg_state}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("abort_ram_intact", ram[16], 32'h5A5A5A5A);
    rst = 1'b1;
    @(negedge clk);
    run_txn(mk(1'b0, 2'b10, 0, 32'h40, 32'h0, 32'h5A5A5A5A, 0, 4'h0, 32'h0));

    chk("exp_q_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
